// File: rtl/ap_mult_seq_ctrl_if.sv
// Operand/product handshake bundle for ap_mult_seq_ctrl.
// master = operand producer and product consumer, slave = the controller.
interface ap_mult_seq_ctrl_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] prod;
  logic           busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, prod, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, prod, busy
  );
endinterface

// File: rtl/ap_mult_seq_ctrl.sv
// Sequential WxW approximate multiplier: one 4x4 AND-array + ppcom core reused per nibble pair.
// Optional macro AP_SEQ_SKIP_ZERO_EN skips nibble pairs where either nibble is zero.
module ap_mult_seq_ctrl #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ap_mult_seq_ctrl_if.slave   bus
);
  localparam int NI = W / 4;
  localparam int N  = NI * NI;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d, prod_q, prod_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

  logic [KW-1:0]   k_cur;
  logic [31:0]     pass_i, pass_j;
  logic [3:0]      a_nib, b_nib;
  logic [15:0]     pp;
  logic [7:0]      core_res;
  logic [PW-1:0]   add_val;
  logic            last_pass;

  // AND-array partial products: pp[4r+c] = a_nib[c] & b_nib[r]
  for (genvar gi = 0; gi < 16; gi++) begin : g_pp
    assign pp[gi] = a_nib[gi % 4] & b_nib[gi / 4];
  end

`ifdef AP_SEQ_SKIP_ZERO_EN
  logic [N-1:0]  mask_q, mask_d, mask_in;
  logic [KW-1:0] enc [N+1];

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign mask_in[gi] = (|bus.a[4*(gi%NI) +: 4]) & (|bus.b[4*(gi/NI) +: 4]);
  end

  // Lowest pending pass index, built as a priority chain from the top down
  assign enc[N] = '0;
  for (genvar gi = 0; gi < N; gi++) begin : g_enc
    assign enc[gi] = mask_q[gi] ? KW'(gi) : enc[gi+1];
  end
  assign k_cur     = enc[0];
  assign last_pass = ((mask_q & (mask_q - N'(1))) == '0);
`else
  assign k_cur     = cnt_q;
  assign last_pass = (cnt_q == KW'(N - 1));
`endif

  // ppcom: columns 0..2 are OR-compressed (no carries), columns 3..6 are summed exactly
  always_comb begin
    pass_i   = 32'(k_cur) % NI;
    pass_j   = 32'(k_cur) / NI;
    a_nib    = 4'(a_q >> (4 * pass_i));
    b_nib    = 4'(b_q >> (4 * pass_j));
    core_res = ((8'(pp[3]) + 8'(pp[6]) + 8'(pp[9]) + 8'(pp[12])) << 3)
             + ((8'(pp[7]) + 8'(pp[10]) + 8'(pp[13])) << 4)
             + ((8'(pp[11]) + 8'(pp[14])) << 5)
             + (8'(pp[15]) << 6);
    core_res = core_res | {5'b0, pp[2] | pp[5] | pp[8], pp[1] | pp[4], pp[0]};
    add_val  = PW'(core_res) << (4 * (pass_i + pass_j));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
`ifdef AP_SEQ_SKIP_ZERO_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef AP_SEQ_SKIP_ZERO_EN
          mask_d  = mask_in;
          if (mask_in == '0) begin
            state_d = DONE;
            prod_d  = '0;
          end
`endif
        end
      end
      RUN: begin
        acc_d = acc_q + add_val;
        cnt_d = cnt_q + KW'(1);
`ifdef AP_SEQ_SKIP_ZERO_EN
        mask_d = mask_q & (mask_q - N'(1));
`endif
        if (last_pass) begin
          state_d = DONE;
          prod_d  = acc_q + add_val;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AP_SEQ_SKIP_ZERO_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef AP_SEQ_SKIP_ZERO_EN
      mask_q      <= mask_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.prod      = prod_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ap_mult_seq_ctrl.sv
// Scoreboard bench for ap_mult_seq_ctrl (W=8): directed vectors, stall/abort cases, random traffic.
module tb_ap_mult_seq_ctrl;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ap_mult_seq_ctrl_if #(.W(W)) bus ();
  ap_mult_seq_ctrl #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_push   = 0;
  int          n_out    = 0;
  logic [15:0] exp_q [$];
  bit          rand_ready = 1'b0;
  logic        ready_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // 4x4 approximate product: exact product with the three low columns replaced by column ORs
  function automatic int ppcom_ref(input int x, input int y);
    int b [4];
    int c [4];
    int exact_low, or_low;
    for (int n = 0; n < 4; n++) begin
      b[n] = (x >> n) & 1;
      c[n] = (y >> n) & 1;
    end
    exact_low = b[0]*c[0] + 2*(b[1]*c[0] + b[0]*c[1]) + 4*(b[2]*c[0] + b[1]*c[1] + b[0]*c[2]);
    or_low    = (b[0] & c[0]) | (((b[1] & c[0]) | (b[0] & c[1])) << 1)
              | (((b[2] & c[0]) | (b[1] & c[1]) | (b[0] & c[2])) << 2);
    return x * y - exact_low + or_low;
  endfunction

  function automatic logic [15:0] golden(input int a, input int b);
    int sum = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        sum += ppcom_ref((a >> (4*i)) & 15, (b >> (4*j)) & 15) << (4*(i+j));
    return 16'(sum);
  endfunction

  function automatic int exp_latency(input int a, input int b);
    int cnt = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (((a >> (4*i)) & 15) != 0 && ((b >> (4*j)) & 15) != 0) cnt++;
`ifdef AP_SEQ_SKIP_ZERO_EN
    return cnt;
`else
    return N + 0 * cnt;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Monitor: a transfer completes at the edge following a negedge that sees valid & ready
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_out++;
      chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("prod", 32'(bus.prod), 32'(exp_q.pop_front()));
      $display("out #%0d prod=%04h", n_out, bus.prod);
    end
  end

  // Called #1 after a posedge; returns #1 after the edge where out_valid is first seen
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] expv);
    int t = 0;
    int lat = 0;
    while (bus.in_ready !== 1'b1 && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 500) chk("accept_timeout", 32'(t), 32'd0);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 'x;
    bus.b = 'x;
    exp_q.push_back(expv);
    n_push++;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(exp_latency(a, b)));
    $display("op a=%02h b=%02h exp=%04h lat=%0d", a, b, expv, lat);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 500) chk("drain_timeout", 32'(t), 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    logic [7:0]  ra, rb;
    bit          seen;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_prod", 32'(bus.prod), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    do_op(8'h01, 8'h01, 16'h0001);
    do_op(8'h10, 8'h01, 16'h0010);
    do_op(8'hFF, 8'hFF, golden(8'hFF, 8'hFF));
    do_op(8'h00, 8'hA5, 16'h0000);
    drain();

    // Stall in DONE for 10 cycles with a competing in_valid
    ready_force = 1'b0;
    @(posedge clk); #1;
    do_op(8'h5A, 8'hC3, golden(8'h5A, 8'hC3));
    held = bus.prod;
    bus.in_valid = 1'b1;
    bus.a = 8'h11;
    bus.b = 8'h22;
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_prod", 32'(bus.prod), 32'(held));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    ready_force = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;

    // Abort with reset while pass 2 is in flight
    bus.in_valid = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    chk("pre_abort_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_prod", 32'(bus.prod), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("no_valid_after_abort", 32'(seen), 32'd0);
    do_op(8'h03, 8'h02, golden(8'h03, 8'h02));
    drain();

    // Random traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0: ra = ra & 8'hF0;
        1: rb = rb & 8'h0F;
        2: ra = 8'h00;
        default: ;
      endcase
      do_op(ra, rb, golden(ra, rb));
    end
    drain();
    rand_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("out_count", 32'(n_out), 32'(n_push));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ap_mult_seq_ctrl.md
# ap_mult_seq_ctrl

Sequential controller that computes a W×W unsigned approximate product by time-multiplexing one 4×4 approximate multiplier core, one nibble pair per cycle. The core is an AND-array partial-product generator feeding `ppcom`, which yields an 8-bit result. The block sequences nibble-pair passes, shifts and accumulates the core results, and exposes valid/ready handshakes on both sides. It sits between operand producers and the accuracy-evaluation datapath in the multiplier harness.

## Interface
- `W`, default 8: operand width. Must be a multiple of 4 and at least 4. N = (W/4)² core passes.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: controller can accept operands.
- `a`  in  W: multiplicand.
- `b`  in  W: multiplier.
- `out_valid`  out  1: product valid.
- `out_ready`  in  1: consumer accepts product.
- `prod`  out  2W: accumulated approximate product.
- `busy`  out  1: high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid&in_ready`, latch `a`/`b`, clear the accumulator and pass counter, then go to RUN (or to DONE when the skip feature gives zero passes).
- RUN:
  - Pass k, with i = k mod (W/4) (a-nibble) and j = k div (W/4) (b-nibble). i is the inner loop.
  - Core inputs are `a[4i+:4]` and `b[4j+:4]`. Partial product bit `pp[4r+c]` = `a_nib[c] & b_nib[r]`.
  - Update: acc += zero-extend(core_res) << 4(i+j). The accumulator is 2W bits and wraps modulo 2^2W; no overflow flag.
  - After the last pass, go to DONE.
- DONE:
  - `out_valid`=1 and `prod`=acc, both stable until `out_ready`.
  - On `out_valid&out_ready`, go to IDLE.
- No new operands are accepted before the handshake completes; `in_ready`=0 in RUN and DONE.
- Reset values: state=IDLE, acc=0, counter=0, `prod`=0, `out_valid`=0, `busy`=0. `in_ready`=1 once `rst_n` is high.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. The partial product is discarded and no `out_valid` pulse is produced.
- Core is combinational; no extra pipeline stage.
- Operands X while `in_valid`=0 must not affect state.

## Timing
- Accept at edge T; passes occupy edges T+1..T+N; `out_valid` rises after edge T+N. Latency is N+1 cycles from accept to `out_valid`.
- If `out_ready` is already high when `out_valid` rises, the handshake completes at the next edge. IDLE with `in_ready`=1 follows; the next accept is possible one cycle later.
- Throughput: one product per N+2 cycles.
- `in_ready` and `out_valid` are registered-state decodes; no combinational path from `out_ready` to `in_ready`.

## Configuration
- `AP_SEQ_SKIP_ZERO_EN` defined:
  - At accept, register an N-bit mask of passes where both nibbles are nonzero.
  - RUN visits only masked passes in ascending k order, one per cycle; latency = 1 + popcount(mask).
  - If mask = 0, go IDLE→DONE directly with acc=0; latency = 1.
  - `prod` is unchanged by skipping, since zero nibbles give core_res = 0.
- Undefined: all N passes always execute; fixed latency N+1.

## Test plan
- Reset, then W=8, a=8'h01, b=8'h01, `out_ready`=1: `out_valid` after 5 cycles (macro off) or 2 cycles (on); `prod`=16'h0001.
- a=8'h10, b=8'h01: `prod`=16'h0010, from the single nonzero pass at i=1, j=0. a=8'hFF, b=8'hFF: `prod` equals the bit-accurate golden model summing four ppcom results with shifts 0/4/4/8.
- a=0, b=8'hA5: `prod`=0. With the macro defined, `out_valid` one cycle after accept.
- Hold `out_ready`=0 for 10 cycles in DONE: `prod` and `out_valid` stable, `in_ready`=0, and a second `in_valid` is ignored.
- Pulse `rst_n`=0 during pass 2: all outputs return to reset values asynchronously. The next operation a=8'h03, b=8'h02 completes normally against the golden model.
- Back-to-back random operands, 1000 transactions, random `out_ready` stalls: every `prod` matches the golden model and no transaction is lost or duplicated.
